// File: rtl/deck_shuffler_if.sv
// Card-source bundle between deck_shuffler (master) and the blackjack controller (slave).
interface deck_shuffler_if #(
    parameter int CARD_W = 6
) ();
    logic              shuffle_en;
    logic              card_ready;
    logic [CARD_W-1:0] card;
    logic              card_valid;
    logic              load_flag;
    logic              busy;
    logic [CARD_W-1:0] remaining;

    modport master (
        input  shuffle_en, card_ready,
        output card, card_valid, load_flag, busy, remaining
    );

    modport slave (
        output shuffle_en, card_ready,
        input  card, card_valid, load_flag, busy, remaining
    );
endinterface

// File: rtl/deck_shuffler.sv
// Builds a DECK_SIZE-card deck, Fisher-Yates shuffles it from a free-running LFSR, streams it out.
// Optional macro SHUFFLER_ENTROPY_EN adds port entropy_in, XORed into the LFSR feedback.
module deck_shuffler #(
    parameter int          DECK_SIZE = 52,
    parameter int          CARD_W    = 6,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
`ifdef SHUFFLER_ENTROPY_EN
    input  logic entropy_in,
`endif
    deck_shuffler_if.master bus
);
    localparam int AW = $clog2(DECK_SIZE);
    localparam int IW = $clog2(DECK_SIZE + 1);

    typedef enum logic [2:0] {IDLE, INIT, SHUFFLE, STREAM, DONE} state_e;

    state_e            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic              en_q;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CARD_W-1:0] card_q, card_d;
    logic [CARD_W-1:0] remaining_q, remaining_d;
    logic              valid_q, valid_d;
    logic [CARD_W-1:0] deck_q [DECK_SIZE];

    logic          fb, start, hs, accept, last_init, last_card;
    logic [AW-1:0] i_idx, mask, r_val;

    // idx_q counts 0..N-1 in INIT, doubles as the Fisher-Yates i in SHUFFLE, and the read pointer in STREAM.
    assign i_idx     = idx_q[AW-1:0];
    assign r_val     = lfsr_q[AW-1:0] & mask;
    assign start     = bus.shuffle_en & ~en_q & (state_q == IDLE || state_q == DONE);
    assign hs        = valid_q & bus.card_ready;
    assign accept    = (state_q == SHUFFLE) && (r_val <= i_idx);
    assign last_init = (state_q == INIT) && (idx_q == IW'(DECK_SIZE - 1));
    assign last_card = (state_q == STREAM) && hs && (remaining_q == CARD_W'(1));

    // Smallest all-ones value covering i, so rejection sampling stays unbiased.
    always_comb begin
        mask = i_idx;
        for (int b = 1; b < AW; b++) mask = mask | (mask >> b);
    end

    always_comb begin
        fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
`ifdef SHUFFLER_ENTROPY_EN
        fb     = fb ^ entropy_in;
        lfsr_d = (lfsr_q == '0) ? LFSR_SEED : {fb, lfsr_q[15:1]};
`else
        lfsr_d = {fb, lfsr_q[15:1]};
`endif
    end

    // NOTE: non-blocking assignments make every register sample pre-edge values; the deck swap depends on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start) state_d = INIT;
            INIT:       if (last_init) state_d = SHUFFLE;
            SHUFFLE:    if (accept && i_idx == AW'(1)) state_d = STREAM;
            STREAM:     if (last_card) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.load_flag = (state_q == STREAM);
        bus.busy      = state_q inside {INIT, SHUFFLE, STREAM};
    end

    always_comb begin
        idx_d       = idx_q;
        card_d      = card_q;
        valid_d     = valid_q;
        remaining_d = remaining_q;
        unique case (state_q)
            IDLE, DONE: if (start) idx_d = '0;
            INIT:       if (!last_init) idx_d = idx_q + 1'b1;
            SHUFFLE: begin
                if (accept) begin
                    idx_d = idx_q - 1'b1;
                    if (i_idx == AW'(1)) remaining_d = CARD_W'(DECK_SIZE);
                end
            end
            STREAM: begin
                if (hs) remaining_d = remaining_q - 1'b1;
                // Refill on entry or after each handshake; running out of deck ends the run.
                if (!valid_q || hs) begin
                    if (idx_q < IW'(DECK_SIZE)) begin
                        card_d  = deck_q[idx_q[AW-1:0]];
                        valid_d = 1'b1;
                        idx_d   = idx_q + 1'b1;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q      <= LFSR_SEED;
            en_q        <= 1'b0;
            idx_q       <= '0;
            card_q      <= '0;
            valid_q     <= 1'b0;
            remaining_q <= '0;
        end else begin
            lfsr_q      <= lfsr_d;
            en_q        <= bus.shuffle_en;
            idx_q       <= idx_d;
            card_q      <= card_d;
            valid_q     <= valid_d;
            remaining_q <= remaining_d;
        end
    end

    // NOTE: the deck is plain storage with no reset; INIT rewrites every entry before it is read.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            deck_q[i_idx] <= CARD_W'(idx_q);
        end else if (accept) begin
            deck_q[i_idx] <= deck_q[r_val];
            deck_q[r_val] <= deck_q[i_idx];
        end
    end

    assign bus.card       = card_q;
    assign bus.card_valid = valid_q;
    assign bus.remaining  = remaining_q;
endmodule
